// File: rtl/msi001_cfg_seq.sv
// msi001_cfg_seq: power-on init table streamer and runtime write arbiter for the
// MSI001 tuner's 3-wire SPI writer, in the SPI clock domain.
module msi001_cfg_seq #(
  parameter int N_INIT = 4,
  parameter logic [24*N_INIT-1:0] INIT_WORDS = 96'h000004_000003_000002_000001,
  parameter int POR_DELAY = 1000,
  parameter int GAP_CYCLES = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_reinit,
  input  logic        i_req_valid,
  input  logic [23:0] i_req_data,
  output logic        o_req_ready,
  output logic        o_spi_start,
  output logic [23:0] o_spi_data,
  input  logic        i_spi_busy,
  output logic        o_init_done,
  output logic        o_cfg_busy,
  output logic        o_error
);
  localparam int PW = $clog2(POR_DELAY + 1);
  typedef enum logic [2:0] {S_POR, S_ISSUE, S_ACK, S_XFER, S_GAP, S_READY, S_ERROR} state_t;
  state_t        r_state;
  logic [PW-1:0] r_por_cnt;
  logic [7:0]    r_to_cnt, r_gap_cnt;
  logic [3:0]    r_idx;
  logic [23:0]   r_req_word, r_spi_data;
  logic          r_init, r_reinit_pend, r_req_ready, r_spi_start, r_init_done, r_cfg_busy, r_error;
  logic          w_reinit, w_gap_done, w_timeout, w_restart;
  logic [23:0]   w_init_word;
  assign w_init_word = INIT_WORDS[24*int'(r_idx) +: 24];
  assign w_reinit    = i_reinit | r_reinit_pend;
  assign w_gap_done  = r_gap_cnt == 8'(GAP_CYCLES - 1);
  assign w_timeout   = r_to_cnt == 8'(ACK_TIMEOUT);
  // a pending reinit acts at once when idle, otherwise only once the bus is free again
  assign w_restart = w_reinit & ((r_state inside {S_POR, S_READY, S_ERROR}) |
                                 (r_state == S_GAP & w_gap_done) |
                                 (r_state == S_ACK & ~i_spi_busy & w_timeout));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_POR;
      r_por_cnt     <= '0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_idx         <= '0;
      r_req_word    <= '0;
      r_spi_data    <= '0;
      r_init        <= 1'b1;
      r_reinit_pend <= 1'b0;
      r_req_ready   <= 1'b0;
      r_spi_start   <= 1'b0;
      r_init_done   <= 1'b0;
      r_cfg_busy    <= 1'b1;
      r_error       <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      if (i_reinit) r_reinit_pend <= 1'b1;
      if (w_restart) begin
        r_state       <= S_ISSUE;
        r_idx         <= '0;
        r_init        <= 1'b1;
        r_init_done   <= 1'b0;
        r_error       <= 1'b0;
        r_reinit_pend <= 1'b0;
        r_req_ready   <= 1'b0;
        r_cfg_busy    <= 1'b1;
      end else begin
        case (r_state)
          S_POR: begin
            if (r_por_cnt == PW'(POR_DELAY - 1)) begin
              r_state <= S_ISSUE;
              r_idx   <= '0;
              r_init  <= 1'b1;
            end else begin
              r_por_cnt <= r_por_cnt + 1'b1;
            end
          end
          S_ISSUE: begin
            r_spi_start <= 1'b1;
            r_spi_data  <= r_init ? w_init_word : r_req_word;
            r_to_cnt    <= '0;
            r_state     <= S_ACK;
          end
          S_ACK: begin
            if (i_spi_busy) begin
              r_state <= S_XFER;
            end else if (w_timeout) begin
              r_state     <= S_ERROR;
              r_error     <= 1'b1;
              r_init_done <= 1'b0;
              r_cfg_busy  <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          S_XFER: begin
            if (!i_spi_busy) begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end
          S_GAP: begin
            if (!w_gap_done) begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end else if (r_init && r_idx != 4'(N_INIT - 1)) begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_state     <= S_READY;
              r_req_ready <= 1'b1;
              r_cfg_busy  <= 1'b0;
              if (r_init) r_init_done <= 1'b1;
            end
          end
          S_READY: begin
            if (i_req_valid) begin
              r_req_word  <= i_req_data;
              r_req_ready <= 1'b0;
              r_init      <= 1'b0;
              r_cfg_busy  <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
          S_ERROR: r_req_ready <= 1'b0;
          default: r_state <= S_POR;
        endcase
      end
    end
  end
  assign o_req_ready = r_req_ready;
  assign o_spi_start = r_spi_start;
  assign o_spi_data  = r_spi_data;
  assign o_init_done = r_init_done;
  assign o_cfg_busy  = r_cfg_busy;
  assign o_error     = r_error;
endmodule

// File: tb/tb_msi001_cfg_seq.sv
// tb_msi001_cfg_seq: scoreboard bench for msi001_cfg_seq with a randomized-frame
// SPI writer model; expected start words and start cycles come from the timing rules.
module tb_msi001_cfg_seq;
  localparam int P = 1000, G = 4, T = 16;
  logic clk = 0, rst_n = 0, reinit = 0, req_valid = 0, busy = 0;
  logic [23:0] req_data = 0;
  logic req_ready, spi_start, init_done, cfg_busy, error;
  logic [23:0] spi_data;
  int cyc = 0, last_fall = 0, last_start = 0, n_starts = 0, n_cmp = 0, n_err = 0, fix_f = 26;
  logic drop_en = 0;
  logic [23:0] drop_word = 0;
  typedef struct {logic [23:0] w; int at;} exp_t;
  exp_t exp_q[$];

  msi001_cfg_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_reinit(reinit), .i_req_valid(req_valid),
    .i_req_data(req_data), .o_req_ready(req_ready), .o_spi_start(spi_start),
    .o_spi_data(spi_data), .i_spi_busy(busy), .o_init_done(init_done),
    .o_cfg_busy(cfg_busy), .o_error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: an init pass is words 1..4; the first start's cycle is given, later ones follow a gap
  task automatic push_init(input int first_at);
    for (int k = 0; k < 4; k++) exp_q.push_back('{24'(k + 1), k == 0 ? first_at : -1});
  endtask

  function automatic logic sig(input int w);
    return w == 0 ? init_done : w == 1 ? error : w == 2 ? req_ready :
           w == 3 ? (spi_start && spi_data == 24'd3) : w == 4 ? busy : spi_start;
  endfunction

  task automatic wait_for(input int w, input string nm, output int at);
    at = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sig(w)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_%s: never seen within 3000 cycles", nm);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // SPI writer: busy high for f cycles starting the cycle after the start pulse
  initial begin
    int f;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        if (drop_en && spi_data == drop_word) continue;
        f = fix_f > 0 ? fix_f : int'($urandom_range(1, 30));
        @(posedge clk);
        #1 busy = 1;
        repeat (f) @(posedge clk);
        #1 busy = 0;
        last_fall = cyc;
      end
    end
  end

  // monitor: every start pulse must match the next expected word at the expected cycle
  initial begin
    exp_t e;
    int ea;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        last_start = cyc;
        n_starts++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: got data %0h at cycle %0d, expected none", spi_data, cyc);
        end else begin
          e = exp_q.pop_front();
          ea = e.at < 0 ? last_fall + G + 2 : e.at;
          chk("start_data", 32'(spi_data), 32'(e.w));
          chk("start_cycle", 32'(cyc), 32'(ea));
        end
      end
    end
  end

  initial begin
    int t, at, ns;
    logic [23:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_data", 32'(spi_data), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cfg_busy", 32'(cfg_busy), 1);
    tick;
    rst_n = 1;
    push_init(cyc + P + 1);
    wait_for(0, "init_done", at);
    chk("init_done_cycle", 32'(at), 32'(last_fall + G + 1));
    chk("init_queue_empty", 32'(exp_q.size()), 0);
    chk("init_cfg_busy", 32'(cfg_busy), 0);
    fix_f = 0;
    for (int i = 0; i < 4; i++) begin
      d = i == 0 ? 24'hABCDEF : 24'($urandom);
      wait_for(2, "ready", at);
      tick;
      req_valid = 1;
      req_data = d;
      exp_q.push_back('{d, cyc + 2});
      tick;
      req_valid = 0;
      @(negedge clk);
      chk("ready_drop", 32'(req_ready), 0);
      wait_for(2, "ready_back", at);
      chk("ready_back_cycle", 32'(at), 32'(last_fall + G + 1));
    end
    tick;
    reinit = 1;
    drop_en = 1;
    drop_word = 24'd2;
    push_init(cyc + 2);
    tick;
    reinit = 0;
    wait_for(1, "error", at);
    chk("error_cycle", 32'(at), 32'(last_start + T + 1));
    chk("error_init_done", 32'(init_done), 0);
    chk("error_ready", 32'(req_ready), 0);
    chk("error_cfg_busy", 32'(cfg_busy), 0);
    exp_q.delete();
    ns = n_starts;
    repeat (60) @(negedge clk);
    chk("error_no_starts", 32'(n_starts), 32'(ns));
    chk("error_held", 32'(error), 1);
    tick;
    reinit = 1;
    drop_en = 0;
    push_init(cyc + 2);
    tick;
    reinit = 0;
    @(negedge clk);
    chk("error_cleared", 32'(error), 0);
    wait_for(0, "reinit_done", at);
    chk("reinit_done_cycle", 32'(at), 32'(last_fall + G + 1));
    tick;
    reinit = 1;
    push_init(cyc + 2);
    tick;
    reinit = 0;
    wait_for(3, "word3", at);
    wait_for(4, "busy3", at);
    tick;
    reinit = 1;
    exp_q.delete();
    push_init(-1);
    tick;
    reinit = 0;
    @(negedge clk);
    chk("mid_init_done", 32'(init_done), 0);
    wait_for(0, "mid_done", at);
    chk("mid_done_cycle", 32'(at), 32'(last_fall + G + 1));
    chk("mid_queue_empty", 32'(exp_q.size()), 0);
    d = 24'($urandom);
    tick;
    reinit = 1;
    req_valid = 1;
    req_data = d;
    push_init(cyc + 2);
    tick;
    reinit = 0;
    @(negedge clk);
    chk("race_ready", 32'(req_ready), 0);
    wait_for(0, "race_done", at);
    chk("race_done_cycle", 32'(at), 32'(last_fall + G + 1));
    chk("race_ready_back", 32'(req_ready), 1);
    exp_q.push_back('{d, at + 2});
    tick;
    req_valid = 0;
    wait_for(2, "race_ready2", at);
    chk("race_ready2_cycle", 32'(at), 32'(last_fall + G + 1));
    d = 24'($urandom);
    tick;
    req_valid = 1;
    req_data = d;
    exp_q.push_back('{d, cyc + 2});
    tick;
    req_valid = 0;
    wait_for(5, "last_start", at);
    #2 rst_n = 0;
    #1;
    chk("arst_start", 32'(spi_start), 0);
    chk("arst_data", 32'(spi_data), 0);
    chk("arst_cfg_busy", 32'(cfg_busy), 1);
    chk("arst_init_done", 32'(init_done), 0);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
